// File: rtl/seq_divider.sv
// Sequential restoring divider: DW-bit unsigned dividend by VW-bit divisor,
// one quotient bit per clock, with a start/busy/done handshake.
module seq_divider #(
  parameter int DW = 8,
  parameter int VW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          dz
);

  localparam int CW = (DW > 1) ? $clog2(DW) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt;
  logic [DW-1:0] dvd_sh;
  logic [VW-1:0] dvs;
  logic [VW-1:0] pr;
  logic [DW-1:0] q_work;
  logic          zero_flag;

  logic [VW:0]   pr_shift;
  logic [VW:0]   trial;
  logic [VW-1:0] pr_next;
  logic [DW-1:0] q_next;
  logic          accept;
  logic          last_cycle;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_cycle) state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The stored partial remainder is always below the divisor, so its
  // (VW+1)-th bit is zero and only VW bits are kept between cycles.
  always_comb begin
    accept     = ((state == IDLE) || (state == DONE)) && start;
    last_cycle = (state == RUN) && (cnt == CW'(DW - 1));
    pr_shift   = {pr, dvd_sh[DW-1]};
    trial      = pr_shift - {1'b0, dvs};
    pr_next    = trial[VW] ? pr_shift[VW-1:0] : trial[VW-1:0];
    q_next     = {q_work[DW-2:0], ~trial[VW]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dvd_sh    <= '0;
      dvs       <= '0;
      pr        <= '0;
      q_work    <= '0;
      cnt       <= '0;
      zero_flag <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      dz        <= 1'b0;
    end else if (accept) begin
      dvd_sh    <= dividend;
      dvs       <= divisor;
      pr        <= '0;
      q_work    <= '0;
      cnt       <= '0;
      zero_flag <= (divisor == '0);
    end else if (state == RUN) begin
      dvd_sh <= {dvd_sh[DW-2:0], 1'b0};
      pr     <= pr_next;
      q_work <= q_next;
      cnt    <= cnt + CW'(1);
      if (last_cycle) begin
        quotient  <= zero_flag ? '1 : q_next;
        remainder <= zero_flag ? '0 : pr_next;
        dz        <= zero_flag;
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule
